// File: rtl/axi4_lite_fanout_pkg.sv
// axi4_lite_fanout_pkg: FSM encoding, response codes and address decode.
// Shared by the write fanout; AXI4_LITE_FANOUT_DECERR_EN enables the error sink.
package axi4_lite_fanout_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ROUTE = 3'b010,
    FLUSH = 3'b100
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int MAX_NM = 16;
  localparam int MAX_A  = 64;

  typedef logic [MAX_NM-1:0][MAX_A-1:0] base_t;

  typedef struct packed {
    logic       miss;
    logic [3:0] tgt;
  } dec_t;

  // Bases ascend, so the last base not above addr owns it.
  function automatic dec_t decode(
    input logic [MAX_A-1:0] addr,
    input base_t            base,
    input logic [MAX_A-1:0] limit,
    input int               nm
  );
    dec_t r;
    r.miss = addr >= limit;
    r.tgt  = '0;
    for (int j = 1; j < MAX_NM; j++)
      if (j < nm && addr >= base[j])
        r.tgt = 4'(j);
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// axi4_lite_addr_decode: combinational address-range to target decode.
// Returns the region index and a miss flag for addresses at or above LIMIT.
module axi4_lite_addr_decode
  import axi4_lite_fanout_pkg::*;
#(
  parameter int                   A     = 32,
  parameter int                   NM    = 4,
  parameter logic [NM-1:0][A-1:0] BASE  = '0,
  parameter logic [A-1:0]         LIMIT = '1
) (
  input  logic [A-1:0]          addr,
  output logic [$clog2(NM)-1:0] tgt,
  output logic                  miss
);

  localparam int TW = $clog2(NM);

  logic [MAX_A-1:0] addr_x;
  logic [MAX_A-1:0] limit_x;
  base_t            base_x;
  dec_t             d;

  always_comb begin
    addr_x           = '0;
    addr_x[A-1:0]    = addr;
    limit_x          = '0;
    limit_x[A-1:0]   = LIMIT;
    base_x           = '0;
    for (int j = 0; j < NM; j++)
      base_x[j][A-1:0] = BASE[j];
    d = decode(addr_x, base_x, limit_x, NM);
  end

  assign tgt  = TW'(d.tgt);
  assign miss = d.miss;

endmodule

// File: rtl/axi4_lite_fanout_fifo.sv
// axi4_lite_fanout_fifo: small synchronous fifo used as channel adapter.
// Push is ignored when full, pop is ignored when empty.
module axi4_lite_fanout_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = cnt == (PW+1)'(DEPTH);
  assign empty    = cnt == '0;
  assign pop_data = mem[rp];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_data;
        wp      <= wp + 1'b1;
      end
      if (do_pop)
        rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_fanout_wr_n.sv
// axi4_lite_fanout_wr_n: AXI4-Lite write fanout, one slave port to NM masters.
// Define AXI4_LITE_FANOUT_DECERR_EN to answer misses with DECERR internally.
module axi4_lite_fanout_wr_n
  import axi4_lite_fanout_pkg::*;
#(
  parameter int                   A     = 32,
  parameter int                   N     = 4,
  parameter int                   I     = 1,
  parameter int                   NM    = 4,
  parameter int                   D     = 4,
  parameter logic [NM-1:0][A-1:0] BASE  = '0,
  parameter logic [A-1:0]         LIMIT = '1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [A-1:0]             s_awaddr,
  input  logic [I-1:0]             s_awid,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [8*N-1:0]           s_wdata,
  input  logic [N-1:0]             s_wstrb,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  output logic [1:0]               s_bresp,
  output logic [I-1:0]             s_bid,
  output logic [NM-1:0]            m_awvalid,
  input  logic [NM-1:0]            m_awready,
  output logic [NM-1:0][A-1:0]     m_awaddr,
  output logic [NM-1:0][I-1:0]     m_awid,
  output logic [NM-1:0]            m_wvalid,
  input  logic [NM-1:0]            m_wready,
  output logic [NM-1:0][8*N-1:0]   m_wdata,
  output logic [NM-1:0][N-1:0]     m_wstrb,
  input  logic [NM-1:0]            m_bvalid,
  output logic [NM-1:0]            m_bready,
  input  logic [NM-1:0][1:0]       m_bresp,
  input  logic [NM-1:0][I-1:0]     m_bid
);

  localparam int TW  = $clog2(NM);
  localparam int SW  = $clog2(NM + 1);
  localparam int CW  = $clog2(D + 1);
  localparam int AWW = A + I;
  localparam int WW  = 8 * N + N;
  localparam int BW  = I + 2;

  logic           aw_full;
  logic           aw_empty;
  logic           w_full;
  logic           w_empty;
  logic           sb_full;
  logic           sb_empty;
  logic [AWW-1:0] aw_head;
  logic [WW-1:0]  w_head;
  logic [BW-1:0]  b_head;
  logic [BW-1:0]  b_data;
  logic           b_valid;
  logic           b_push;
  logic           do_pop;
  logic           tgt_full;
  logic [TW-1:0]  dec_tgt;
  logic           dec_miss;
  logic [SW-1:0]  tgt;
  logic [SW-1:0]  sel;
  logic [CW-1:0]  count;
  logic [NM-1:0]  b_own;
  logic [NM-1:0]  maw_full;
  logic [NM-1:0]  maw_empty;
  logic [NM-1:0]  mw_full;
  logic [NM-1:0]  mw_empty;
  state_t         state;

`ifdef AXI4_LITE_FANOUT_DECERR_EN
  logic           sink_pend;
  logic [I-1:0]   sink_id;
`endif

  axi4_lite_fanout_fifo #(.W(AWW)) u_s_aw (
    .aclk, .areset,
    .push(s_awvalid), .push_data({s_awid, s_awaddr}), .full(aw_full),
    .pop(do_pop), .pop_data(aw_head), .empty(aw_empty)
  );

  axi4_lite_fanout_fifo #(.W(WW)) u_s_w (
    .aclk, .areset,
    .push(s_wvalid), .push_data({s_wstrb, s_wdata}), .full(w_full),
    .pop(do_pop), .pop_data(w_head), .empty(w_empty)
  );

  axi4_lite_fanout_fifo #(.W(BW)) u_s_b (
    .aclk, .areset,
    .push(b_push), .push_data(b_data), .full(sb_full),
    .pop(s_bready), .pop_data(b_head), .empty(sb_empty)
  );

  assign s_awready        = !aw_full;
  assign s_wready         = !w_full;
  assign s_bvalid         = !sb_empty;
  assign {s_bid, s_bresp} = b_head;

  axi4_lite_addr_decode #(
    .A(A), .NM(NM), .BASE(BASE), .LIMIT(LIMIT)
  ) u_dec (
    .addr(aw_head[A-1:0]),
    .tgt (dec_tgt),
    .miss(dec_miss)
  );

`ifdef AXI4_LITE_FANOUT_DECERR_EN
  assign tgt = dec_miss ? SW'(NM) : SW'(dec_tgt);
`else
  assign tgt = dec_miss ? SW'(NM - 1) : SW'(dec_tgt);
`endif

  always_comb begin
    tgt_full = 1'b1;
    for (int j = 0; j < NM; j++)
      if (tgt == SW'(j))
        tgt_full = maw_full[j] | mw_full[j];
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    if (tgt == SW'(NM))
      tgt_full = sink_pend;
`endif
  end

  assign do_pop = !aw_empty && !w_empty && !tgt_full &&
                  (count < CW'(D)) && (state == ROUTE) &&
                  (sel == tgt);

  for (genvar j = 0; j < NM; j++) begin : g_m
    logic           push_j;
    logic [AWW-1:0] aw_out;
    logic [WW-1:0]  w_out;

    assign push_j = do_pop && (tgt == SW'(j));

    axi4_lite_fanout_fifo #(.W(AWW)) u_aw (
      .aclk, .areset,
      .push(push_j), .push_data(aw_head), .full(maw_full[j]),
      .pop(m_awready[j]), .pop_data(aw_out), .empty(maw_empty[j])
    );

    axi4_lite_fanout_fifo #(.W(WW)) u_w (
      .aclk, .areset,
      .push(push_j), .push_data(w_head), .full(mw_full[j]),
      .pop(m_wready[j]), .pop_data(w_out), .empty(mw_empty[j])
    );

    assign m_awvalid[j]             = !maw_empty[j];
    assign m_wvalid[j]              = !mw_empty[j];
    assign {m_awid[j], m_awaddr[j]} = aw_out;
    assign {m_wstrb[j], m_wdata[j]} = w_out;
  end

  // Response path follows the registered sel so it holds steady in FLUSH.
  always_comb begin
    b_valid  = 1'b0;
    b_data   = '0;
    m_bready = '0;
    b_own    = '0;
    for (int j = 0; j < NM; j++)
      if (sel == SW'(j)) begin
        b_own[j]    = 1'b1;
        b_valid     = m_bvalid[j];
        b_data      = {m_bid[j], m_bresp[j]};
        m_bready[j] = !sb_full;
      end
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    if (sel == SW'(NM)) begin
      b_valid = sink_pend;
      b_data  = {sink_id, RESP_DECERR};
    end
`endif
  end

  assign b_push = b_valid && !sb_full;

`ifdef AXI4_LITE_FANOUT_DECERR_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      sink_pend <= 1'b0;
      sink_id   <= '0;
    end else if (do_pop && tgt == SW'(NM)) begin
      sink_pend <= 1'b1;
      sink_id   <= aw_head[AWW-1:A];
    end else if (b_push && sel == SW'(NM)) begin
      sink_pend <= 1'b0;
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset)
      count <= '0;
    else if (do_pop && !b_push)
      count <= count + 1'b1;
    else if (!do_pop && b_push)
      count <= count - 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (!aw_empty) begin
            state <= ROUTE;
            sel   <= tgt;
          end
        end
        (state == ROUTE): begin
          if (aw_empty) begin
            if (count == '0)
              state <= IDLE;
          end else if (tgt != sel) begin
            if (count != '0)
              state <= FLUSH;
            else
              sel <= tgt;
          end
        end
        (state == FLUSH): begin
          if (count == '0) begin
            if (!aw_empty) begin
              state <= ROUTE;
              sel   <= tgt;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge aclk) begin
    if (!areset) begin
      assert (!(|(m_bvalid & ~b_own)))
        else $error("B response on unselected master port");
      assert (!(b_push && !do_pop && count == '0))
        else $error("B response with no write outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_fanout_wr_n.sv
// tb_axi4_lite_fanout_wr_n: directed scoreboard bench for the write fanout.
// Master ports are modelled as slaves answering B in AW order per port.
module tb_axi4_lite_fanout_wr_n;
  import axi4_lite_fanout_pkg::*;

  localparam int A  = 32;
  localparam int N  = 4;
  localparam int I  = 1;
  localparam int NM = 4;
  localparam int D  = 4;
  localparam logic [NM-1:0][A-1:0] BASE =
    {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [A-1:0] LIMIT = 32'h4000;

  logic                  aclk;
  logic                  areset;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [A-1:0]          s_awaddr;
  logic [I-1:0]          s_awid;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [8*N-1:0]        s_wdata;
  logic [N-1:0]          s_wstrb;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [1:0]            s_bresp;
  logic [I-1:0]          s_bid;
  logic [NM-1:0]         m_awvalid;
  logic [NM-1:0]         m_awready;
  logic [NM-1:0][A-1:0]  m_awaddr;
  logic [NM-1:0][I-1:0]  m_awid;
  logic [NM-1:0]         m_wvalid;
  logic [NM-1:0]         m_wready;
  logic [NM-1:0][8*N-1:0] m_wdata;
  logic [NM-1:0][N-1:0]  m_wstrb;
  logic [NM-1:0]         m_bvalid = '0;
  logic [NM-1:0]         m_bready;
  logic [NM-1:0][1:0]    m_bresp;
  logic [NM-1:0][I-1:0]  m_bid = '0;

  int nchk = 0;
  int npass = 0;

  logic [31:0] want_aw [NM][$];
  logic [31:0] want_w  [NM][$];
  logic [2:0]  want_b  [$];
  bit          bq      [NM][$];
  int          aw_cnt  [NM];
  logic [NM-1:0] hold = '0;

  axi4_lite_fanout_wr_n #(
    .A(A), .N(N), .I(I), .NM(NM), .D(D), .BASE(BASE), .LIMIT(LIMIT)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bresp(s_bresp), .s_bid(s_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bresp(m_bresp), .m_bid(m_bid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    nchk++;
    assert (got === want) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask

  // Master-side slave models and scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    if (areset) begin
      want_b.delete();
      for (int j = 0; j < NM; j++) begin
        bq[j].delete();
        want_aw[j].delete();
        want_w[j].delete();
      end
    end else begin
      for (int j = 0; j < NM; j++) begin
        if (m_awvalid[j] && m_awready[j]) begin
          aw_cnt[j]++;
          chk($sformatf("m%0d_aw_expected", j),
              64'(want_aw[j].size() != 0), 64'd1);
          if (want_aw[j].size() != 0)
            chk($sformatf("m%0d_awaddr", j), 64'(m_awaddr[j]),
                64'(want_aw[j].pop_front()));
          bq[j].push_back(m_awid[j][0]);
        end
        if (m_wvalid[j] && m_wready[j]) begin
          chk($sformatf("m%0d_w_expected", j),
              64'(want_w[j].size() != 0), 64'd1);
          if (want_w[j].size() != 0)
            chk($sformatf("m%0d_wdata", j), 64'(m_wdata[j]),
                64'(want_w[j].pop_front()));
        end
        if (m_bvalid[j] && m_bready[j] && bq[j].size() != 0)
          void'(bq[j].pop_front());
      end
      if (s_bvalid && s_bready) begin
        chk("s_b_expected", 64'(want_b.size() != 0), 64'd1);
        if (want_b.size() != 0)
          chk("s_bid_bresp", 64'({s_bid, s_bresp}),
              64'(want_b.pop_front()));
      end
    end
  end

  always @(posedge aclk) begin
    #2;
    for (int j = 0; j < NM; j++) begin
      m_bvalid[j] = !hold[j] && bq[j].size() != 0;
      m_bid[j]    = (bq[j].size() != 0) ? bq[j][0] : 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input int port, input bit id, input logic [1:0] resp);
    bit ad = 0;
    bit wd = 0;
    int n = 0;
    if (port >= 0) begin
      want_aw[port].push_back(a);
      want_w[port].push_back(d);
    end
    want_b.push_back({id, resp});
    s_awaddr  = a;
    s_awid    = id;
    s_wdata   = d;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    while (!(ad && wd) && n < 60) begin
      @(negedge aclk);
      if (s_awvalid && s_awready) ad = 1;
      if (s_wvalid && s_wready) wd = 1;
      @(posedge aclk);
      #1;
      if (ad) s_awvalid = 1'b0;
      if (wd) s_wvalid = 1'b0;
      n++;
    end
    if (!(ad && wd)) begin
      chk("send_accept", 64'(ad && wd), 64'd1);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    int left;
    do begin
      tick(1);
      left = want_b.size();
      for (int j = 0; j < NM; j++)
        left += want_aw[j].size();
      n++;
    end while ((left != 0 || dut.count != 0) && n < 300);
    chk(tag, 64'(left), 64'd0);
  endtask

  task automatic wait_count(input int v, input string tag);
    int n = 0;
    while (dut.count != v && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(dut.count), 64'(v));
  endtask

  int snap [NM];

  task automatic take_snap();
    for (int j = 0; j < NM; j++)
      snap[j] = aw_cnt[j];
  endtask

  initial begin
    areset    = 1'b1;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awid    = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '1;
    s_bready  = 1'b1;
    m_awready = '1;
    m_wready  = '1;
    m_bresp   = '0;
    tick(3);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    chk("rst_count", 64'(dut.count), 64'd0);
    chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_s_bvalid", 64'(s_bvalid), 64'd0);
    areset = 1'b0;
    tick(1);

    // single write lands only on m[1]
    take_snap();
    send(32'h1004, 32'hA5, 1, 1'b0, RESP_OKAY);
    wait_idle("t1_done");
    chk("t1_m1_aw", 64'(aw_cnt[1] - snap[1]), 64'd1);
    chk("t1_others_aw", 64'(aw_cnt[0] + aw_cnt[2] + aw_cnt[3]
        - snap[0] - snap[2] - snap[3]), 64'd0);

    // target switch waits for m[0] B
    take_snap();
    hold[0] = 1'b1;
    send(32'h0000, 32'h11, 0, 1'b0, RESP_OKAY);
    send(32'h2000, 32'h22, 2, 1'b1, RESP_OKAY);
    tick(20);
    chk("t2_no_m2_aw", 64'(aw_cnt[2] - snap[2]), 64'd0);
    chk("t2_flush", 64'(dut.state), 64'(FLUSH));
    hold[0] = 1'b0;
    wait_idle("t2_done");
    chk("t2_m2_aw", 64'(aw_cnt[2] - snap[2]), 64'd1);

    // outstanding limit D on m[3]
    take_snap();
    hold[3] = 1'b1;
    for (int k = 0; k < 6; k++)
      send(32'h3000 + 32'(4 * k), 32'h300 + 32'(k), 3, 1'(k), RESP_OKAY);
    tick(10);
    chk("t3_aw_stall", 64'(aw_cnt[3] - snap[3]), 64'd4);
    chk("t3_count_full", 64'(dut.count), 64'(D));
    chk("t3_s_awready", 64'(s_awready), 64'd0);
    hold[3] = 1'b0;
    wait_idle("t3_done");
    chk("t3_aw_all", 64'(aw_cnt[3] - snap[3]), 64'd6);
    chk("t3_count_zero", 64'(dut.count), 64'd0);

    // address above LIMIT
    take_snap();
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    send(32'h5000, 32'h55, -1, 1'b1, RESP_DECERR);
    wait_idle("t4_done");
    chk("t4_no_master_aw", 64'(aw_cnt[0] + aw_cnt[1] + aw_cnt[2] + aw_cnt[3]
        - snap[0] - snap[1] - snap[2] - snap[3]), 64'd0);
`else
    send(32'h5000, 32'h55, 3, 1'b1, RESP_OKAY);
    wait_idle("t4_done");
    chk("t4_m3_aw", 64'(aw_cnt[3] - snap[3]), 64'd1);
`endif

    // simultaneous pop and B at count 2
    hold[0] = 1'b1;
    send(32'h0000, 32'h61, 0, 1'b0, RESP_OKAY);
    send(32'h0004, 32'h62, 0, 1'b1, RESP_OKAY);
    wait_count(2, "t6_count2");
    want_aw[0].push_back(32'h0008);
    want_w[0].push_back(32'h63);
    want_b.push_back({1'b0, RESP_OKAY});
    s_awaddr  = 32'h0008;
    s_awid    = 1'b0;
    s_wdata   = 32'h63;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    tick(1);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("t6_pre", 64'(dut.count), 64'd2);
    hold[0] = 1'b0;
    tick(1);
    chk("t6_simul", 64'(dut.count), 64'd2);
    wait_idle("t6_done");

    // reset with writes outstanding
    hold[1] = 1'b1;
    for (int k = 0; k < 3; k++)
      send(32'h1000 + 32'(4 * k), 32'h70 + 32'(k), 1, 1'(k), RESP_OKAY);
    wait_count(3, "t5_count3");
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    chk("t5_state", 64'(dut.state), 64'(IDLE));
    chk("t5_count", 64'(dut.count), 64'd0);
    chk("t5_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("t5_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("t5_s_bvalid", 64'(s_bvalid), 64'd0);
    hold[1] = 1'b0;
    take_snap();
    send(32'h0000, 32'h99, 0, 1'b1, RESP_OKAY);
    wait_idle("t5_done");
    chk("t5_m0_aw", 64'(aw_cnt[0] - snap[0]), 64'd1);

    tick(5);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
